// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU-control decoder for the EX stage with MULT/DIV sequencing.
// Optional feature: define ALU_CTRL_ILLEGAL_TRAP_EN to drop undefined R-type ops and raise a sticky illegal flag.
module alu_ctrl_seq #(
  parameter int ALUOP_W    = 3,
  parameter int FUNC_W     = 6,
  parameter int CTR_W      = 3,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNC_W-1:0]  funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTR_W-1:0]   alu_ctr,
  output logic               md_busy,
  output logic               illegal
);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [2:0]       MD_CTR   = 3'b011;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic             out_valid_reg;
  logic [2:0]       alu_ctr_reg;
  logic             md_busy_reg;
  logic             illegal_reg;

  logic             is_rtype;
  logic             is_mult;
  logic             is_div;
  logic             funct_known;
  logic             drop_op;
  logic             accept;
  logic [2:0]       decode_ctr;

  assign is_rtype = (alu_op[2:0] == 3'b111);
  assign is_mult  = is_rtype && (funct == FUNC_W'(6'h18));
  assign is_div   = is_rtype && (funct == FUNC_W'(6'h1A));

  // Only the low three funct bits select the R-type ALU code.
  always_comb begin
    decode_ctr  = 3'b000;
    funct_known = 1'b0;
    if (is_rtype) begin
      case (funct[2:0])
        3'b010: begin decode_ctr = 3'b101; funct_known = 1'b1; end
        3'b011: begin decode_ctr = 3'b110; funct_known = 1'b1; end
        3'b100: begin decode_ctr = 3'b000; funct_known = 1'b1; end
        3'b101: begin decode_ctr = 3'b001; funct_known = 1'b1; end
        3'b111: begin decode_ctr = 3'b100; funct_known = 1'b1; end
        default: begin decode_ctr = 3'b000; funct_known = 1'b0; end
      endcase
    end else begin
      case (alu_op[2:0])
        3'b001:  decode_ctr = 3'b001;
        3'b100:  decode_ctr = 3'b100;
        3'b101:  decode_ctr = 3'b101;
        3'b110:  decode_ctr = 3'b110;
        default: decode_ctr = 3'b000;
      endcase
    end
  end

  assign drop_op  = TRAP_EN && is_rtype && !is_mult && !is_div && !funct_known;
  assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      alu_ctr_reg   <= 3'b000;
      md_busy_reg   <= 1'b0;
      illegal_reg   <= 1'b0;
    end else if (flush) begin
      // Flush wins over any accept in the same cycle; the illegal flag survives.
      state_reg     <= IDLE;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      md_busy_reg   <= 1'b0;
    end else begin
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_mult || is_div) begin
              state_reg   <= RUN;
              count_reg   <= is_mult ? MUL_LOAD : DIV_LOAD;
              md_busy_reg <= 1'b1;
            end else if (drop_op) begin
              illegal_reg <= 1'b1;
            end else begin
              alu_ctr_reg   <= decode_ctr;
              out_valid_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (count_reg == '0) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b1;
            alu_ctr_reg   <= MD_CTR;
            md_busy_reg   <= 1'b0;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign md_busy   = md_busy_reg;
  assign illegal   = TRAP_EN && illegal_reg;

  // Upper bits of a wider select bus are zero-filled.
  for (genvar gi = 0; gi < CTR_W; gi++) begin : g_ctr
    if (gi < 3) begin : g_code
      assign alu_ctr[gi] = alu_ctr_reg[gi];
    end else begin : g_zero
      assign alu_ctr[gi] = 1'b0;
    end
  end

endmodule
